alu_flag_writeback: RTL and testbench

ALU_FLAG_WRITEBACK -- requirements
Module: alu_flag_writeback

---
 rtl/arm_cond_pkg.sv | 23 ++
 rtl/alu_flag_writeback_if.sv | 37 +++
 rtl/cond_check.sv | 39 +++
 rtl/alu_flag_writeback.sv | 103 ++++++++++
 tb/tb_alu_flag_writeback.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/arm_cond_pkg.sv
// ARM condition codes, NZCV bit positions and the writeback entry shared by
// alu_flag_writeback and cond_check.
package arm_cond_pkg;

   typedef enum logic [3:0] {
      COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
      COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
      COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
      COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF
   } cond_e;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   typedef struct packed {
      logic [31:0] result;
      logic [3:0]  rd;
      logic        cond_pass;
   } wb_entry_t;

endpackage

// File: rtl/alu_flag_writeback_if.sv
// ALU-side handshake, writeback-side handshake and the live CPSR flags.
// master = ALU producer / writeback consumer, slave = alu_flag_writeback.
interface alu_flag_writeback_if;

   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_result;
   logic        in_zero;
   logic        in_carry;
   logic        in_overflow;
   logic        in_negative;
   logic        in_set_flags;
   logic        in_logical;
   logic        in_shift_carry;
   logic [3:0]  in_cond;
   logic [3:0]  in_rd;

   logic        wb_valid;
   logic        wb_ready;
   logic [31:0] wb_result;
   logic [3:0]  wb_rd;
   logic        wb_cond_pass;
   logic [3:0]  nzcv;

   modport master (
      output in_valid, in_result, in_zero, in_carry, in_overflow, in_negative,
             in_set_flags, in_logical, in_shift_carry, in_cond, in_rd, wb_ready,
      input  in_ready, wb_valid, wb_result, wb_rd, wb_cond_pass, nzcv
   );

   modport slave (
      input  in_valid, in_result, in_zero, in_carry, in_overflow, in_negative,
             in_set_flags, in_logical, in_shift_carry, in_cond, in_rd, wb_ready,
      output in_ready, wb_valid, wb_result, wb_rd, wb_cond_pass, nzcv
   );

endinterface

// File: rtl/cond_check.sv
// Combinational ARM condition-field evaluation against a NZCV snapshot.
module cond_check
   import arm_cond_pkg::*;
(
   input  logic [3:0] cond,
   input  logic [3:0] nzcv,
   output logic       pass
);

   logic w_n, w_z, w_c, w_v;

   assign w_n = nzcv[FLAG_N];
   assign w_z = nzcv[FLAG_Z];
   assign w_c = nzcv[FLAG_C];
   assign w_v = nzcv[FLAG_V];

   always_comb begin
      pass = 1'b0;
      case (cond)
         COND_EQ: pass = w_z;
         COND_NE: pass = !w_z;
         COND_CS: pass = w_c;
         COND_CC: pass = !w_c;
         COND_MI: pass = w_n;
         COND_PL: pass = !w_n;
         COND_VS: pass = w_v;
         COND_VC: pass = !w_v;
         COND_HI: pass = w_c & !w_z;
         COND_LS: pass = !w_c | w_z;
         COND_GE: pass = (w_n == w_v);
         COND_LT: pass = (w_n != w_v);
         COND_GT: pass = !w_z & (w_n == w_v);
         COND_LE: pass = w_z | (w_n != w_v);
         COND_AL: pass = 1'b1;
         default: pass = 1'b0;
      endcase
   end

endmodule

// File: rtl/alu_flag_writeback.sv
// Condition check + CPSR flag update + writeback buffer for ALU results.
// FLAG_WB_SKID_EN: two-entry buffer with registered in_ready; else one register.
module alu_flag_writeback
   import arm_cond_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   alu_flag_writeback_if.slave  bus
);

   logic [3:0] r_nzcv;
   logic [3:0] w_nzcv_nxt;
   logic       w_pass;
   logic       w_accept;
   wb_entry_t  w_new;
   wb_entry_t  r_out;
   logic       r_out_vld;

   // Evaluated against flags held before this edge, so back-to-back words
   // naturally see the previous word's update.
   cond_check u_cond (
      .cond (bus.in_cond),
      .nzcv (r_nzcv),
      .pass (w_pass)
   );

   assign w_accept = bus.in_valid & bus.in_ready;
   assign w_new    = '{result: bus.in_result, rd: bus.in_rd, cond_pass: w_pass};

   always_comb begin
      w_nzcv_nxt = r_nzcv;
      if (w_accept && w_pass && bus.in_set_flags) begin
         w_nzcv_nxt[FLAG_N] = bus.in_negative;
         w_nzcv_nxt[FLAG_Z] = bus.in_zero;
         if (bus.in_logical) begin
            w_nzcv_nxt[FLAG_C] = bus.in_shift_carry;
         end else begin
            w_nzcv_nxt[FLAG_C] = bus.in_carry;
            w_nzcv_nxt[FLAG_V] = bus.in_overflow;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_nzcv <= 4'b0000;
      else        r_nzcv <= w_nzcv_nxt;
   end

`ifdef FLAG_WB_SKID_EN
   wb_entry_t r_skid;
   logic      r_skid_vld;
   logic      r_in_ready;

   assign bus.in_ready = r_in_ready;

   // Skid only fills while the output register is stalled; it is always
   // older than anything still upstream, so it drains first.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out      <= '0;
         r_out_vld  <= 1'b0;
         r_skid     <= '0;
         r_skid_vld <= 1'b0;
         r_in_ready <= 1'b0;
      end else if (r_skid_vld) begin
         if (bus.wb_ready) begin
            r_out      <= r_skid;
            r_skid_vld <= 1'b0;
            r_in_ready <= 1'b1;
         end
      end else if (!r_out_vld || bus.wb_ready) begin
         r_out_vld  <= w_accept;
         if (w_accept) r_out <= w_new;
         r_in_ready <= 1'b1;
      end else if (w_accept) begin
         r_skid     <= w_new;
         r_skid_vld <= 1'b1;
         r_in_ready <= 1'b0;
      end else begin
         r_in_ready <= 1'b1;
      end
   end
`else
   assign bus.in_ready = !r_out_vld | bus.wb_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out     <= '0;
         r_out_vld <= 1'b0;
      end else if (bus.in_ready) begin
         r_out_vld <= w_accept;
         if (w_accept) r_out <= w_new;
      end
   end
`endif

   assign bus.wb_valid     = r_out_vld;
   assign bus.wb_result    = r_out.result;
   assign bus.wb_rd        = r_out.rd;
   assign bus.wb_cond_pass = r_out.cond_pass;
   assign bus.nzcv         = r_nzcv;

endmodule

// File: tb/tb_alu_flag_writeback.sv
// Directed bench for alu_flag_writeback; expectations follow FLAG_WB_SKID_EN.
module tb_alu_flag_writeback;

   logic clk = 1'b0;
   logic rst_n;
   int   n_tests = 0;
   int   n_fail  = 0;

`ifdef FLAG_WB_SKID_EN
   localparam int   HOLD    = 2;
   localparam logic RST_RDY = 1'b0;
`else
   localparam int   HOLD    = 1;
   localparam logic RST_RDY = 1'b1;
`endif

   // Sweep groups: flags to load, then pass bit i expected for cond i.
   logic [3:0]  fl [3] = '{4'b1001, 4'b0110, 4'b0010};
   logic [15:0] pv [3] = '{16'h565A, 16'h66A5, 16'h55A6};

   alu_flag_writeback_if bus ();

   alu_flag_writeback dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // f = {N,Z,C,V} as produced by the ALU
   task automatic put(input logic [3:0] cond, input logic [3:0] rd, input logic [31:0] res,
                      input logic [3:0] f, input logic set, input logic lg, input logic shc);
      bus.in_valid       = 1'b1;
      bus.in_cond        = cond;
      bus.in_rd          = rd;
      bus.in_result      = res;
      {bus.in_negative, bus.in_zero, bus.in_carry, bus.in_overflow} = f;
      bus.in_set_flags   = set;
      bus.in_logical     = lg;
      bus.in_shift_carry = shc;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1);
   end

   initial begin
      logic [35:0] q[$];
      logic [35:0] e;
      logic [31:0] held_res;
      logic [3:0]  held_rd;
      int          n_acc;
      int          n_extra;
      int          n_seen;

      put(4'h0, 4'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
      bus.in_valid = 1'b0;
      bus.wb_ready = 1'b1;
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      chk("rst_nzcv",      bus.nzcv, 0);
      chk("rst_wb_valid",  bus.wb_valid, 0);
      chk("rst_wb_result", bus.wb_result, 0);
      chk("rst_wb_rd",     bus.wb_rd, 0);
      chk("rst_wb_pass",   bus.wb_cond_pass, 0);
      chk("rst_in_ready",  bus.in_ready, RST_RDY);
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      tick();
      chk("rdy_after_rst", bus.in_ready, 1);

      // ADD 0xA5A5A5A5 + 0x5A5A5A5A, S=1, AL
      put(4'hE, 4'd1, 32'hFFFF_FFFF, 4'b1000, 1'b1, 1'b0, 1'b0);
      tick();
      bus.in_valid = 1'b0;
      chk("add_valid",  bus.wb_valid, 1);
      chk("add_result", bus.wb_result, 32'hFFFF_FFFF);
      chk("add_rd",     bus.wb_rd, 1);
      chk("add_pass",   bus.wb_cond_pass, 1);
      chk("add_nzcv",   bus.nzcv, 4'b1000);
      tick();
      chk("add_drained", bus.wb_valid, 0);

      // Failed NE must not touch flags
      put(4'hE, 4'd2, 32'h0, 4'b0100, 1'b1, 1'b0, 1'b0);
      tick();
      chk("z_set_nzcv", bus.nzcv, 4'b0100);
      put(4'h1, 4'd3, 32'h1234, 4'b1000, 1'b1, 1'b0, 1'b0);
      tick();
      bus.in_valid = 1'b0;
      chk("ne_pass", bus.wb_cond_pass, 0);
      chk("ne_rd",   bus.wb_rd, 3);
      chk("ne_nzcv", bus.nzcv, 4'b0100);

      // Logical op: C from shifter, V kept
      put(4'hE, 4'd4, 32'h0, 4'b0011, 1'b1, 1'b0, 1'b0);
      tick();
      chk("cv_nzcv", bus.nzcv, 4'b0011);
      put(4'hE, 4'd4, 32'h0, 4'b0110, 1'b1, 1'b1, 1'b0);
      tick();
      bus.in_valid = 1'b0;
      chk("logic_nzcv", bus.nzcv, 4'b0101);

      // CMP then MOVEQ back-to-back
      put(4'hE, 4'd0, 32'h0, 4'b0100, 1'b1, 1'b0, 1'b0);
      tick();
      chk("cmp1_nzcv", bus.nzcv, 4'b0100);
      put(4'h0, 4'd5, 32'h55, 4'b0000, 1'b0, 1'b0, 1'b0);
      tick();
      bus.in_valid = 1'b0;
      chk("moveq1_pass", bus.wb_cond_pass, 1);
      chk("moveq1_rd",   bus.wb_rd, 5);
      chk("moveq1_nzcv", bus.nzcv, 4'b0100);
      put(4'hE, 4'd0, 32'h1, 4'b0000, 1'b1, 1'b0, 1'b0);
      tick();
      chk("cmp2_nzcv", bus.nzcv, 4'b0000);
      put(4'h0, 4'd5, 32'h55, 4'b0000, 1'b0, 1'b0, 1'b0);
      tick();
      bus.in_valid = 1'b0;
      chk("moveq2_pass", bus.wb_cond_pass, 0);
      chk("moveq2_rd",   bus.wb_rd, 5);

      // All 16 conditions, streamed one per cycle
      for (int g = 0; g < 3; g++) begin
         put(4'hE, 4'hF, 32'h0, fl[g], 1'b1, 1'b0, 1'b0);
         tick();
         for (int i = 0; i < 16; i++) begin
            put(4'(i), 4'(i), 32'(i), 4'b1111, 1'b0, 1'b0, 1'b0);
            tick();
            chk($sformatf("sweep_g%0d_c%0d_pass", g, i), bus.wb_cond_pass, pv[g][i]);
            chk($sformatf("sweep_g%0d_c%0d_vld", g, i), bus.wb_valid, 1);
            chk($sformatf("sweep_g%0d_c%0d_rd", g, i), bus.wb_rd, i);
         end
         chk($sformatf("sweep_g%0d_nzcv", g), bus.nzcv, fl[g]);
      end
      bus.in_valid = 1'b0;
      tick();
      chk("sweep_drained", bus.wb_valid, 0);

      // Stall 5 cycles with in_valid held high
      bus.wb_ready = 1'b0;
      n_acc = 0;
      held_res = '0;
      held_rd  = '0;
      for (int c = 0; c < 5; c++) begin
         put(4'hE, 4'(8 + n_acc), 32'hC0DE_0000 + 32'(n_acc), 4'b0000, 1'b0, 1'b0, 1'b0);
         #2;
         if (bus.in_ready) begin
            q.push_back({4'(8 + n_acc), 32'hC0DE_0000 + 32'(n_acc)});
            n_acc++;
         end
         tick();
         if (c == 0) begin
            held_res = bus.wb_result;
            held_rd  = bus.wb_rd;
         end else begin
            chk($sformatf("stall_res_c%0d", c), bus.wb_result, held_res);
            chk($sformatf("stall_rd_c%0d", c), bus.wb_rd, held_rd);
            chk($sformatf("stall_vld_c%0d", c), bus.wb_valid, 1);
         end
      end
      chk("stall_count", n_acc, HOLD);
      chk("stall_nzcv", bus.nzcv, 4'b0010);

      bus.in_valid = 1'b0;
      bus.wb_ready = 1'b1;
      n_extra = 0;
      for (int c = 0; c < 8; c++) begin
         if (bus.wb_valid) begin
            if (q.size() == 0) n_extra++;
            else begin
               e = q.pop_front();
               chk($sformatf("drain_rd_c%0d", c), bus.wb_rd, e[35:32]);
               chk($sformatf("drain_res_c%0d", c), bus.wb_result, e[31:0]);
            end
         end
         tick();
      end
      chk("drain_left",  q.size(), 0);
      chk("drain_extra", n_extra, 0);

      // Reset with the buffer full
      bus.wb_ready = 1'b0;
      n_acc = 0;
      for (int c = 0; c < 3; c++) begin
         put(4'hE, 4'(12 + n_acc), 32'hDEAD_0000 + 32'(n_acc), 4'b0000, 1'b0, 1'b0, 1'b0);
         #2;
         if (bus.in_ready) n_acc++;
         tick();
      end
      bus.in_valid = 1'b0;
      chk("prerst_held", n_acc, HOLD);
      chk("prerst_vld",  bus.wb_valid, 1);
      #3 rst_n = 1'b0;
      #1;
      chk("midrst_vld",    bus.wb_valid, 0);
      chk("midrst_nzcv",   bus.nzcv, 0);
      chk("midrst_result", bus.wb_result, 0);
      bus.wb_ready = 1'b1;
      @(posedge clk);
      #2 rst_n = 1'b1;
      n_seen = 0;
      for (int c = 0; c < 5; c++) begin
         tick();
         if (c == 0) chk("postrst_rdy", bus.in_ready, 1);
         if (bus.wb_valid) n_seen++;
      end
      chk("postrst_none", n_seen, 0);

      put(4'hE, 4'd7, 32'h0000_0777, 4'b1010, 1'b1, 1'b0, 1'b0);
      tick();
      bus.in_valid = 1'b0;
      chk("postrst_rd",   bus.wb_rd, 7);
      chk("postrst_res",  bus.wb_result, 32'h0000_0777);
      chk("postrst_nzcv", bus.nzcv, 4'b1010);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
